// File: rtl/sprite_mem_arbiter.sv
// rtl/sprite_mem_arbiter.sv - single-port sprite memory arbiter: round-robin display fetch plus starvation-bounded host port
module sprite_mem_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 10,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int HOST_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rd_valid,
    output logic [DW-1:0]        rd_data,
    input  logic                 host_read,
    input  logic                 host_write,
    input  logic [AW-1:0]        host_address,
    input  logic [DW-1:0]        host_writedata,
    output logic                 host_waitrequest,
    output logic [DW-1:0]        host_readdata,
    output logic                 host_readdatavalid,
    output logic [AW-1:0]        mem_address,
    output logic                 mem_wren,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(HOST_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(HOST_MAX);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [NREQ:0] tag_q [RD_LAT];
    logic [NREQ:0] tag_d;

    logic          host_pend;
    logic          host_gnt;
    logic          disp_gnt;
    logic          found;
    logic [PW-1:0] gnt_idx;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    // Combinational outputs are gated by reset so nothing is granted while held in reset.
    always_comb begin
        host_pend = host_read | host_write;
        host_gnt  = 1'b0;
        disp_gnt  = 1'b0;
        if (reset_n) begin
            if (host_pend && starve_q == STARVE_MAX) begin
                host_gnt = 1'b1;
            end else if (found) begin
                disp_gnt = 1'b1;
            end else if (host_pend) begin
                host_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        gnt              = disp_gnt ? (NREQ'(1) << gnt_idx) : '0;
        host_waitrequest = ~host_gnt;
        mem_wren         = host_gnt & host_write;
        mem_wdata        = mem_wren ? host_writedata : '0;
        if (disp_gnt) begin
            mem_address = req_addr[int'(gnt_idx)*AW +: AW];
        end else if (host_gnt) begin
            mem_address = host_address;
        end else begin
            mem_address = '0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (disp_gnt) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
        end
        starve_d = '0;
        if (host_pend && !host_gnt) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
        end
        tag_d = {gnt, host_gnt & host_read & ~host_write};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            starve_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
            tag_q[0] <= tag_d;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rd_valid           = tag_q[RD_LAT-1][NREQ:1];
    assign host_readdatavalid = tag_q[RD_LAT-1][0];
    assign rd_data            = mem_rdata;
    assign host_readdata      = mem_rdata;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb/tb_sprite_mem_arbiter.sv - self-checking bench for sprite_mem_arbiter
module tb_sprite_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [39:0] req_addr;
    logic [3:0]  gnt, rd_valid;
    logic [15:0] rd_data;
    logic        host_read, host_write;
    logic [9:0]  host_address;
    logic [15:0] host_writedata;
    logic        host_waitrequest;
    logic [15:0] host_readdata;
    logic        host_readdatavalid;
    logic [9:0]  mem_address;
    logic        mem_wren;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        rst3_n;
    logic [3:0]  req3, gnt3, rd_valid3;
    logic [15:0] rd_data3, host_readdata3, mem_wdata3;
    logic        host_waitrequest3, host_readdatavalid3, mem_wren3;
    logic [9:0]  mem_address3;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    sprite_mem_arbiter #(.NREQ(4), .AW(10), .DW(16), .RD_LAT(1), .HOST_MAX(15)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .host_read(host_read), .host_write(host_write), .host_address(host_address),
        .host_writedata(host_writedata), .host_waitrequest(host_waitrequest),
        .host_readdata(host_readdata), .host_readdatavalid(host_readdatavalid),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    sprite_mem_arbiter #(.NREQ(4), .AW(10), .DW(16), .RD_LAT(3), .HOST_MAX(15)) dut3 (
        .clk(clk), .reset_n(rst3_n), .req(req3), .req_addr(40'd0),
        .gnt(gnt3), .rd_valid(rd_valid3), .rd_data(rd_data3),
        .host_read(1'b0), .host_write(1'b0), .host_address(10'd0),
        .host_writedata(16'd0), .host_waitrequest(host_waitrequest3),
        .host_readdata(host_readdata3), .host_readdatavalid(host_readdatavalid3),
        .mem_address(mem_address3), .mem_wren(mem_wren3), .mem_wdata(mem_wdata3),
        .mem_rdata(16'd0)
    );

    // Behavioural memory with one clock of read latency.
    logic [15:0] mem [1024];
    always @(posedge clk) begin
        if (mem_wren) mem[mem_address] <= mem_wdata;
        mem_rdata <= mem[mem_address];
    end

    function automatic logic [15:0] pat(input int a);
        return 16'((a * 37) ^ 16'h5a5a);
    endfunction

    function automatic logic [9:0] raddr(input int i);
        return 10'(10'h100 + i * 3);
    endfunction

    typedef struct {
        logic [3:0]  req;
        logic        hr;
        logic        hw;
        logic [9:0]  haddr;
        logic [15:0] hwd;
        logic [3:0]  egnt;
        logic        ewait;
        logic        ewren;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic        h;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] exp_mem [1024];
    vec_t        tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_cycle(input vec_t v, input string nm);
        exp_t e;
        req = v.req; host_read = v.hr; host_write = v.hw;
        host_address = v.haddr; host_writedata = v.hwd;
        @(negedge clk);
        if (sbq.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_rd_valid"}, 32'(rd_valid), 32'(e.tag));
            chk({nm, "_host_rdv"}, 32'(host_readdatavalid), 32'(e.h));
            if (e.tag != 0) chk({nm, "_rd_data"}, 32'(rd_data), 32'(e.data));
            if (e.h) chk({nm, "_host_rdata"}, 32'(host_readdata), 32'(e.data));
        end
        chk({nm, "_gnt"}, 32'(gnt), 32'(v.egnt));
        chk({nm, "_wait"}, 32'(host_waitrequest), 32'(v.ewait));
        chk({nm, "_wren"}, 32'(mem_wren), 32'(v.ewren));
        if (v.ewren) begin
            chk({nm, "_waddr"}, 32'(mem_address), 32'(v.haddr));
            chk({nm, "_wdata"}, 32'(mem_wdata), 32'(v.hwd));
        end
        e.tag = v.egnt;
        e.h = v.hr & ~v.hw & ~v.ewait;
        e.data = 16'h0;
        for (int i = 0; i < 4; i++) if (v.egnt[i]) e.data = exp_mem[raddr(i)];
        if (e.h) e.data = exp_mem[v.haddr];
        if (v.ewren) exp_mem[v.haddr] = v.hwd;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic hr, input logic hw,
                                input logic [9:0] ha, input logic [15:0] hd,
                                input logic [3:0] eg, input logic ew, input logic ewr);
        vec_t v;
        v.req = r; v.hr = hr; v.hw = hw; v.haddr = ha; v.hwd = hd;
        v.egnt = eg; v.ewait = ew; v.ewren = ewr;
        return v;
    endfunction

    initial begin
        exp_t z;
        for (int a = 0; a < 1024; a++) begin
            mem[a] = pat(a);
            exp_mem[a] = pat(a);
        end
        for (int i = 0; i < 4; i++) req_addr[i*10 +: 10] = raddr(i);

        tbl[0]  = mk(4'b1111, 0, 0, 10'h0,   16'h0,    4'b0001, 1, 0);
        tbl[1]  = mk(4'b1111, 0, 0, 10'h0,   16'h0,    4'b0010, 1, 0);
        tbl[2]  = mk(4'b1111, 0, 0, 10'h0,   16'h0,    4'b0100, 1, 0);
        tbl[3]  = mk(4'b1111, 0, 0, 10'h0,   16'h0,    4'b1000, 1, 0);
        tbl[4]  = mk(4'b1111, 0, 0, 10'h0,   16'h0,    4'b0001, 1, 0);
        tbl[5]  = mk(4'b0010, 0, 0, 10'h0,   16'h0,    4'b0010, 1, 0);
        tbl[6]  = mk(4'b0011, 0, 0, 10'h0,   16'h0,    4'b0001, 1, 0);
        tbl[7]  = mk(4'b0011, 0, 0, 10'h0,   16'h0,    4'b0010, 1, 0);
        tbl[8]  = mk(4'b1001, 0, 0, 10'h0,   16'h0,    4'b1000, 1, 0);
        tbl[9]  = mk(4'b0000, 0, 1, 10'h3A5, 16'hF800, 4'b0000, 0, 1);
        tbl[10] = mk(4'b0000, 1, 0, 10'h3A5, 16'h0,    4'b0000, 0, 0);
        tbl[11] = mk(4'b0000, 0, 0, 10'h0,   16'h0,    4'b0000, 1, 0);
        tbl[12] = mk(4'b0000, 1, 1, 10'h010, 16'h1234, 4'b0000, 0, 1);
        tbl[13] = mk(4'b0000, 1, 0, 10'h010, 16'h0,    4'b0000, 0, 0);

        reset_n = 1'b0; rst3_n = 1'b0; req3 = 4'b0;
        req = 4'b1111; host_read = 1'b1; host_write = 1'b0;
        host_address = 10'h0; host_writedata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wait", 32'(host_waitrequest), 1);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_host_rdv", 32'(host_readdatavalid), 0);
        chk("rst_wren", 32'(mem_wren), 0);
        chk("rst_maddr", 32'(mem_address), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        @(posedge clk); #1;
        reset_n = 1'b1; rst3_n = 1'b1;
        z.tag = 4'b0; z.h = 1'b0; z.data = 16'h0;
        sbq.push_back(z);

        for (int i = 0; i < 14; i++) do_cycle(tbl[i], $sformatf("vec%0d", i));

        // Starvation: pointer is 0 here; 15 display grants, then a forced host read.
        for (int c = 0; c < 15; c++)
            do_cycle(mk(4'b1111, 1, 0, 10'h3A5, 16'h0, 4'(1 << (c % 4)), 1, 0),
                     $sformatf("starve%0d", c));
        do_cycle(mk(4'b1111, 1, 0, 10'h3A5, 16'h0, 4'b0000, 0, 0), "forced_host");
        do_cycle(mk(4'b1111, 0, 0, 10'h0, 16'h0, 4'b1000, 1, 0), "resume_ptr");
        do_cycle(mk(4'b0000, 0, 0, 10'h0, 16'h0, 4'b0000, 1, 0), "drain");

        // RD_LAT=3 instance: normal latency, then reset while a read is in flight.
        req3 = 4'b0001;
        @(negedge clk);
        chk("lat3_gnt0", 32'(gnt3), 32'(4'b0001));
        @(posedge clk); #1;
        req3 = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("lat3_valid_c%0d", c), 32'(rd_valid3), (c == 3) ? 32'(4'b0001) : 0);
            @(posedge clk); #1;
        end
        req3 = 4'b0100;
        @(negedge clk);
        chk("lat3_gnt2", 32'(gnt3), 32'(4'b0100));
        @(posedge clk); #1;
        req3 = 4'b0000;
        rst3_n = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("midrst_valid_c%0d", c), 32'(rd_valid3), 0);
            @(posedge clk); #1;
            if (c == 1) rst3_n = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
